// File: rtl/hv_count_sequencer.sv
// Horizontal/vertical count sequencer clocked on a fast drive clock; the pixel
// clock is sampled as data and its falling edge advances the counters.
module hv_count_sequencer #(
  parameter int H_TOTAL      = 455,
  parameter int V_TOTAL      = 262,
  parameter int HBLANK_START = 384,
  parameter int HBLANK_END   = 8,
  parameter int HSYNC_START  = 400,
  parameter int HSYNC_END    = 432,
  parameter int VBLANK_START = 248,
  parameter int VBLANK_END   = 8,
  parameter int VSYNC_START  = 252,
  parameter int VSYNC_END    = 256
) (
  input  logic       CLK_DRV,
  input  logic       RESET_N,
  input  logic       CLK_N,
  input  logic       RUN,
  output logic [8:0] HCNT,
  output logic [8:0] VCNT,
  output logic       HRESET,
  output logic       VRESET,
  output logic       FRAME_START,
  output logic       HBLANK,
  output logic       HSYNC,
  output logic       VBLANK,
  output logic       VSYNC
);

  if (H_TOTAL < 2 || H_TOTAL > 512) begin : g_bad_h_total
    $error("hv_count_sequencer: H_TOTAL out of range 2..512");
  end
  if (V_TOTAL < 2 || V_TOTAL > 512) begin : g_bad_v_total
    $error("hv_count_sequencer: V_TOTAL out of range 2..512");
  end
  if (HBLANK_START > H_TOTAL || HBLANK_END > H_TOTAL ||
      HSYNC_START > H_TOTAL || HSYNC_END > H_TOTAL) begin : g_bad_h_window
    $error("hv_count_sequencer: horizontal window bound exceeds H_TOTAL");
  end
  if (VBLANK_START > V_TOTAL || VBLANK_END > V_TOTAL ||
      VSYNC_START > V_TOTAL || VSYNC_END > V_TOTAL) begin : g_bad_v_window
    $error("hv_count_sequencer: vertical window bound exceeds V_TOTAL");
  end

  localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [9:0] HB_S = 10'(HBLANK_START);
  localparam logic [9:0] HB_E = 10'(HBLANK_END);
  localparam logic [9:0] HS_S = 10'(HSYNC_START);
  localparam logic [9:0] HS_E = 10'(HSYNC_END);
  localparam logic [9:0] VB_S = 10'(VBLANK_START);
  localparam logic [9:0] VB_E = 10'(VBLANK_END);
  localparam logic [9:0] VS_S = 10'(VSYNC_START);
  localparam logic [9:0] VS_E = 10'(VSYNC_END);

  // START > END means the window wraps through count 0; START == END is never active.
  function automatic logic in_window(input logic [8:0] c, input logic [9:0] s,
                                     input logic [9:0] e);
    logic [9:0] c10;
    c10 = {1'b0, c};
    if (s < e)      return (c10 >= s) && (c10 < e);
    else if (s > e) return (c10 >= s) || (c10 < e);
    else            return 1'b0;
  endfunction

  logic       clk_n_p1;
  logic       fall_p0;
  logic       step_p0;
  logic [8:0] hcnt_nxt;
  logic [8:0] vcnt_nxt;
  logic       hwrap_p0;
  logic       vwrap_p0;

  // Stage 0: pixel-clock fall detect and next-count decode
  always_comb begin
    fall_p0  = clk_n_p1 & ~CLK_N;
    step_p0  = fall_p0 & RUN;
    hcnt_nxt = HCNT;
    vcnt_nxt = VCNT;
    hwrap_p0 = 1'b0;
    vwrap_p0 = 1'b0;
    if (step_p0) begin
      if (HCNT == H_LAST) begin
        hcnt_nxt = 9'd0;
        hwrap_p0 = 1'b1;
        if (VCNT == V_LAST) begin
          vcnt_nxt = 9'd0;
          vwrap_p0 = 1'b1;
        end else begin
          vcnt_nxt = VCNT + 9'd1;
        end
      end else begin
        hcnt_nxt = HCNT + 9'd1;
      end
    end
  end

  // Stage 1: counters, pulses and windows all registered from the next counts
  always_ff @(posedge CLK_DRV or negedge RESET_N) begin
    if (!RESET_N) begin
      clk_n_p1    <= 1'b0;
      HCNT        <= 9'd0;
      VCNT        <= 9'd0;
      HRESET      <= 1'b0;
      VRESET      <= 1'b0;
      FRAME_START <= 1'b0;
      HBLANK      <= in_window(9'd0, HB_S, HB_E);
      HSYNC       <= in_window(9'd0, HS_S, HS_E);
      VBLANK      <= in_window(9'd0, VB_S, VB_E);
      VSYNC       <= in_window(9'd0, VS_S, VS_E);
    end else begin
      clk_n_p1    <= CLK_N;
      HCNT        <= hcnt_nxt;
      VCNT        <= vcnt_nxt;
      HRESET      <= hwrap_p0;
      VRESET      <= vwrap_p0;
      FRAME_START <= vwrap_p0;
      HBLANK      <= in_window(hcnt_nxt, HB_S, HB_E);
      HSYNC       <= in_window(hcnt_nxt, HS_S, HS_E);
      VBLANK      <= in_window(vcnt_nxt, VB_S, VB_E);
      VSYNC       <= in_window(vcnt_nxt, VS_S, VS_E);
    end
  end

endmodule

// File: tb/tb_hv_count_sequencer.sv
// Bench for hv_count_sequencer: a default-sized instance and a tiny-frame
// instance share stimulus and are compared every cycle against a fall-count model.
module tb_hv_count_sequencer;

  localparam int DH = 455, DV = 262;
  localparam int SH = 6,   SV = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_n = 1'b0;
  logic run = 1'b1;

  logic [8:0] d_hcnt, d_vcnt, s_hcnt, s_vcnt;
  logic d_hr, d_vr, d_fs, d_hb, d_hs, d_vb, d_vs;
  logic s_hr, s_vr, s_fs, s_hb, s_hs, s_vb, s_vs;

  hv_count_sequencer u_def (
    .CLK_DRV(clk), .RESET_N(rst_n), .CLK_N(clk_n), .RUN(run),
    .HCNT(d_hcnt), .VCNT(d_vcnt), .HRESET(d_hr), .VRESET(d_vr),
    .FRAME_START(d_fs), .HBLANK(d_hb), .HSYNC(d_hs), .VBLANK(d_vb), .VSYNC(d_vs)
  );

  hv_count_sequencer #(
    .H_TOTAL(SH), .V_TOTAL(SV),
    .HBLANK_START(4), .HBLANK_END(1), .HSYNC_START(4), .HSYNC_END(5),
    .VBLANK_START(3), .VBLANK_END(1), .VSYNC_START(3), .VSYNC_END(3)
  ) u_small (
    .CLK_DRV(clk), .RESET_N(rst_n), .CLK_N(clk_n), .RUN(run),
    .HCNT(s_hcnt), .VCNT(s_vcnt), .HRESET(s_hr), .VRESET(s_vr),
    .FRAME_START(s_fs), .HBLANK(s_hb), .HSYNC(s_hs), .VBLANK(s_vb), .VSYNC(s_vs)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int small_wraps = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail < 40) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic win(input int c, input int s, input int e);
    if (s < e)      return (c >= s) && (c < e);
    else if (s > e) return (c >= s) || (c < e);
    else            return 1'b0;
  endfunction

  // Model: count qualified falls since reset; counts follow by division.
  int   m_n = 0;
  logic m_prev = 1'b0;
  logic m_dh = 1'b0, m_dv = 1'b0, m_sh = 1'b0, m_sv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_prev <= 1'b0;
      m_dh <= 1'b0; m_dv <= 1'b0; m_sh <= 1'b0; m_sv <= 1'b0;
    end else begin
      m_prev <= clk_n;
      if (m_prev && !clk_n && run) begin
        m_n  <= m_n + 1;
        m_dh <= ((m_n + 1) % DH) == 0;
        m_dv <= ((m_n + 1) % (DH * DV)) == 0;
        m_sh <= ((m_n + 1) % SH) == 0;
        m_sv <= ((m_n + 1) % (SH * SV)) == 0;
      end else begin
        m_dh <= 1'b0; m_dv <= 1'b0; m_sh <= 1'b0; m_sv <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int dh, dv, sh, sv;
      dh = m_n % DH; dv = (m_n / DH) % DV;
      sh = m_n % SH; sv = (m_n / SH) % SV;
      chk("def_hcnt", 32'(d_hcnt), dh);
      chk("def_vcnt", 32'(d_vcnt), dv);
      chk("def_hreset", 32'(d_hr), 32'(m_dh));
      chk("def_vreset", 32'(d_vr), 32'(m_dv));
      chk("def_frame_start", 32'(d_fs), 32'(m_dv));
      chk("def_hblank", 32'(d_hb), 32'(win(dh, 384, 8)));
      chk("def_hsync", 32'(d_hs), 32'(win(dh, 400, 432)));
      chk("def_vblank", 32'(d_vb), 32'(win(dv, 248, 8)));
      chk("def_vsync", 32'(d_vs), 32'(win(dv, 252, 256)));
      chk("sm_hcnt", 32'(s_hcnt), sh);
      chk("sm_vcnt", 32'(s_vcnt), sv);
      chk("sm_hreset", 32'(s_hr), 32'(m_sh));
      chk("sm_vreset", 32'(s_vr), 32'(m_sv));
      chk("sm_frame_start", 32'(s_fs), 32'(m_sv));
      chk("sm_hblank", 32'(s_hb), 32'(win(sh, 4, 1)));
      chk("sm_hsync", 32'(s_hs), 32'(win(sh, 4, 5)));
      chk("sm_vblank", 32'(s_vb), 32'(win(sv, 3, 1)));
      chk("sm_vsync", 32'(s_vs), 32'(win(sv, 3, 3)));
      if (s_hr && s_vr && s_fs) small_wraps++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic falls(input int k, input int ph);
    repeat (k) begin
      clk_n = 1'b1;
      repeat (ph) tick();
      clk_n = 1'b0;
      repeat (ph) tick();
    end
  endtask

  typedef struct {
    int   falls;
    logic run;
    int   ph;
    int   exp_h;
    int   exp_v;
    logic exp_hb;
    logic exp_hs;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{453, 1'b1, 10, 454, 0, 1'b1, 1'b0};
    tbl[1]  = '{384, 1'b1, 1, 384, 1, 1'b1, 1'b0};
    tbl[2]  = '{15,  1'b1, 1, 399, 1, 1'b1, 1'b0};
    tbl[3]  = '{1,   1'b1, 1, 400, 1, 1'b1, 1'b1};
    tbl[4]  = '{31,  1'b1, 1, 431, 1, 1'b1, 1'b1};
    tbl[5]  = '{1,   1'b1, 1, 432, 1, 1'b1, 1'b0};
    tbl[6]  = '{22,  1'b1, 1, 454, 1, 1'b1, 1'b0};
    tbl[7]  = '{1,   1'b1, 1, 0,   2, 1'b1, 1'b0};
    tbl[8]  = '{7,   1'b1, 1, 7,   2, 1'b1, 1'b0};
    tbl[9]  = '{1,   1'b1, 1, 8,   2, 1'b0, 1'b0};
    tbl[10] = '{92,  1'b1, 1, 100, 2, 1'b0, 1'b0};
    tbl[11] = '{5,   1'b0, 1, 100, 2, 1'b0, 1'b0};
    tbl[12] = '{1,   1'b1, 1, 101, 2, 1'b0, 1'b0};

    // Reset release with the pixel clock held low: no phantom edge.
    tick();
    chk_en = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("rel_hcnt", 32'(d_hcnt), 0);
    chk("rel_vcnt", 32'(d_vcnt), 0);
    chk("rel_hblank", 32'(d_hb), 1);
    chk("rel_vblank", 32'(d_vb), 1);
    chk("rel_hsync", 32'(d_hs), 0);
    chk("rel_vsync", 32'(d_vs), 0);
    clk_n = 1'b1;
    repeat (10) tick();
    chk("rel_high_hcnt", 32'(d_hcnt), 0);
    clk_n = 1'b0;
    tick();
    chk("first_fall_hcnt", 32'(d_hcnt), 1);
    repeat (9) tick();

    chk("tbl0_hcnt_pre", 32'(d_hcnt), 1);
    falls(tbl[0].falls, tbl[0].ph);
    chk("tbl0_hcnt", 32'(d_hcnt), tbl[0].exp_h);

    // Line wrap: HRESET for exactly one cycle, no frame start.
    clk_n = 1'b1;
    tick();
    clk_n = 1'b0;
    tick();
    chk("wrap_hcnt", 32'(d_hcnt), 0);
    chk("wrap_vcnt", 32'(d_vcnt), 1);
    chk("wrap_hreset", 32'(d_hr), 1);
    chk("wrap_vreset", 32'(d_vr), 0);
    chk("wrap_frame_start", 32'(d_fs), 0);
    tick();
    chk("wrap_hreset_drop", 32'(d_hr), 0);

    for (int i = 1; i < 13; i++) begin
      run = tbl[i].run;
      falls(tbl[i].falls, tbl[i].ph);
      chk($sformatf("tbl%0d_hcnt", i), 32'(d_hcnt), tbl[i].exp_h);
      chk($sformatf("tbl%0d_vcnt", i), 32'(d_vcnt), tbl[i].exp_v);
      chk($sformatf("tbl%0d_hblank", i), 32'(d_hb), 32'(tbl[i].exp_hb));
      chk($sformatf("tbl%0d_hsync", i), 32'(d_hs), 32'(tbl[i].exp_hs));
    end

    // Random pixel-clock and enable activity, checked by the model each cycle.
    for (int i = 0; i < 4000; i++) begin
      clk_n = 1'($urandom % 2);
      run = ($urandom % 8) != 0;
      tick();
    end

    // Advance to line 50, count 200, then hit reset between drive-clock edges.
    rst_n = 1'b0;
    run = 1'b1;
    clk_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    falls(50 * DH + 200, 1);
    chk("pre_rst_hcnt", 32'(d_hcnt), 200);
    chk("pre_rst_vcnt", 32'(d_vcnt), 50);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hcnt", 32'(d_hcnt), 0);
    chk("async_rst_vcnt", 32'(d_vcnt), 0);
    chk("async_rst_hreset", 32'(d_hr), 0);
    chk("async_rst_frame_start", 32'(d_fs), 0);
    chk("async_rst_hblank", 32'(d_hb), 1);
    chk("async_rst_sm_hcnt", 32'(s_hcnt), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    falls(1, 1);
    chk("post_rst_hcnt", 32'(d_hcnt), 1);
    falls(3, 2);
    chk("post_rst_hcnt4", 32'(d_hcnt), 4);
    chk("post_rst_vcnt", 32'(d_vcnt), 0);

    chk_en = 1'b0;
    chk("small_frame_wrap_seen", 32'(small_wraps > 0), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
